// File: rtl/ex_pkg.sv
// Shared types, bundle layout and opcode map for the execute stage.
`ifndef EX_OPCODES_DEFINED
`define EX_OPCODES_DEFINED
`define OP_MOV            5'h00
`define OP_ADD            5'h01
`define OP_SUB            5'h02
`define OP_AND            5'h03
`define OP_OR             5'h04
`define OP_NOT            5'h05
`define OP_CMP            5'h06
`define OP_MULT           5'h07
`define OP_DIV            5'h08
`define OP_OB_CHECK       5'h09
`define OP_VELOCITY_GUARD 5'h0A
`define OP_MOVE_LEFT      5'h0B
`define OP_MOVE_RIGHT     5'h0C
`define OP_STOP           5'h0D
`define OP_CONTINUE       5'h0E
`endif

package ex_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IN_W   = 42;
    localparam int unsigned OUT_W  = 29;
    localparam int unsigned ITER   = DATA_W;
    localparam int unsigned RD_W   = 4;
    localparam int unsigned OPC_W  = 5;

    // Input bundle field offsets: {pad, B, A, opcode, rd}
    localparam int unsigned RD_LSB  = 0;
    localparam int unsigned OPC_LSB = RD_LSB + RD_W;
    localparam int unsigned A_LSB   = OPC_LSB + OPC_W;
    localparam int unsigned B_LSB   = A_LSB + DATA_W;
    localparam int unsigned PAD_BIT = IN_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LEFT     = 2'b00;
    localparam logic [1:0] CMD_RIGHT    = 2'b01;
    localparam logic [1:0] CMD_STOP     = 2'b10;
    localparam logic [1:0] CMD_CONTINUE = 2'b11;

    // Bit positions inside the {Z,N,C,V} flag nibble
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

    typedef struct packed {
        logic              illegal;
        logic [1:0]        cmd;
        logic              cmd_valid;
        logic [3:0]        flags;
        logic              wr_en;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] result;
    } out_bundle_t;

endpackage

// File: rtl/ex_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module ex_muldiv_seq
    import ex_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_div,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] res
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);

    logic                busy_q;
    logic                done_q;
    logic                is_div_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   opb_q;

    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   diff;

    // For divide, acc holds {remainder, quotient} and shifts left each step
    always_comb begin
        acc_step = acc_q;
        rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
        diff     = rem_sh[DATA_W-1:0] - opb_q;
        if (is_div_q) begin
            if (rem_sh >= {1'b0, opb_q}) begin
                acc_step = {diff, acc_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*DATA_W-2:0], 1'b0};
            end
        end else if (opb_q[0]) begin
            acc_step = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            is_div_q <= is_div;
            cnt_q    <= '0;
            acc_q    <= is_div ? {{DATA_W{1'b0}}, a} : '0;
            mcand_q  <= {{DATA_W{1'b0}}, a};
            opb_q    <= b;
        end else if (busy_q) begin
            acc_q   <= acc_step;
            mcand_q <= mcand_q << 1;
            opb_q   <= is_div_q ? opb_q : (opb_q >> 1);
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign res  = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, compare, robot guards and motor commands between two req/ack handshakes.
module ex_stage
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_req,
    output logic             in_ack,
    output logic [OUT_W-1:0] out_data,
    output logic             out_req,
    input  logic             out_ack
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [RD_W-1:0]   in_rd;
    logic [OPC_W-1:0]  in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              unused_pad;

    assign in_rd      = in_data[RD_LSB +: RD_W];
    assign in_op      = in_data[OPC_LSB +: OPC_W];
    assign in_a       = in_data[A_LSB +: DATA_W];
    assign in_b       = in_data[B_LSB +: DATA_W];
    assign unused_pad = in_data[PAD_BIT];

    state_t          state_q, state_d;
    logic            in_ack_q, in_ack_d;
    logic            out_req_q, out_req_d;
    out_bundle_t     out_q, out_d;
    logic            div_q;
    logic            bz_q;
    logic [RD_W-1:0] rd_q;

    logic                capture;
    logic                is_muldiv;
    logic                md_done;
    logic [2*DATA_W-1:0] md_res;

    function automatic out_bundle_t exec_op(input logic [OPC_W-1:0]  op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [RD_W-1:0]   rd);
        out_bundle_t     o;
        logic [DATA_W:0] sum;
        logic            zn;
        o    = '0;
        o.rd = rd;
        zn   = 1'b1;
        sum  = {1'b0, a} + {1'b0, b};
        case (op)
            `OP_MOV: begin
                o.result = a;
                o.wr_en  = 1'b1;
            end
            `OP_ADD: begin
                o.result        = sum[DATA_W-1:0];
                o.wr_en         = 1'b1;
                o.flags[FLAG_C] = sum[DATA_W];
                o.flags[FLAG_V] = (a[MSB] == b[MSB]) && (o.result[MSB] != a[MSB]);
            end
            `OP_SUB, `OP_CMP: begin
                o.result        = a - b;
                o.wr_en         = (op == `OP_SUB);
                o.flags[FLAG_C] = (a < b);
                o.flags[FLAG_V] = (a[MSB] != b[MSB]) && (o.result[MSB] != a[MSB]);
            end
            `OP_AND: begin
                o.result = a & b;
                o.wr_en  = 1'b1;
            end
            `OP_OR: begin
                o.result = a | b;
                o.wr_en  = 1'b1;
            end
            `OP_NOT: begin
                o.result = ~a;
                o.wr_en  = 1'b1;
            end
            `OP_OB_CHECK: begin
                o.result = (a < b) ? DATA_W'(1) : '0;
                o.wr_en  = 1'b1;
            end
            `OP_VELOCITY_GUARD: begin
                o.result        = (a > b) ? b : a;
                o.wr_en         = 1'b1;
                o.flags[FLAG_V] = (a > b);
            end
            `OP_MOVE_LEFT:  begin zn = 1'b0; o.cmd_valid = 1'b1; o.cmd = CMD_LEFT;     end
            `OP_MOVE_RIGHT: begin zn = 1'b0; o.cmd_valid = 1'b1; o.cmd = CMD_RIGHT;    end
            `OP_STOP:       begin zn = 1'b0; o.cmd_valid = 1'b1; o.cmd = CMD_STOP;     end
            `OP_CONTINUE:   begin zn = 1'b0; o.cmd_valid = 1'b1; o.cmd = CMD_CONTINUE; end
            // Iterative ops are finished by the sequencer path, never here
            `OP_MULT, `OP_DIV: zn = 1'b0;
            default: begin
                zn        = 1'b0;
                o.illegal = 1'b1;
            end
        endcase
        if (zn) begin
            o.flags[FLAG_Z] = (o.result == '0);
            o.flags[FLAG_N] = o.result[MSB];
        end
        return o;
    endfunction

    function automatic out_bundle_t muldiv_out(input logic                is_div,
                                               input logic [2*DATA_W-1:0] acc,
                                               input logic                b_zero,
                                               input logic [RD_W-1:0]     rd);
        out_bundle_t o;
        o        = '0;
        o.rd     = rd;
        o.wr_en  = 1'b1;
        o.result = acc[DATA_W-1:0];
        if (is_div) begin
            o.flags[FLAG_V] = b_zero;
        end else begin
            o.flags[FLAG_C] = |acc[2*DATA_W-1:DATA_W];
            o.flags[FLAG_V] = |acc[2*DATA_W-1:DATA_W];
        end
        o.flags[FLAG_Z] = (o.result == '0);
        o.flags[FLAG_N] = o.result[MSB];
        return o;
    endfunction

    assign is_muldiv = (in_op == `OP_MULT) || (in_op == `OP_DIV);

    ex_muldiv_seq u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (capture && is_muldiv),
        .is_div (in_op == `OP_DIV),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .res    (md_res)
    );

    // Handshake FSM: next state and registered outputs
    always_comb begin
        state_d   = state_q;
        in_ack_d  = 1'b0;
        out_req_d = out_req_q;
        out_d     = out_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req && !in_ack_q) begin
                    capture  = 1'b1;
                    in_ack_d = 1'b1;
                    if (is_muldiv) begin
                        state_d = BUSY;
                    end else begin
                        state_d   = OUT;
                        out_req_d = 1'b1;
                        out_d     = exec_op(in_op, in_a, in_b, in_rd);
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d   = OUT;
                    out_req_d = 1'b1;
                    out_d     = muldiv_out(div_q, md_res, bz_q, rd_q);
                end
            end
            OUT: begin
                if (out_ack) begin
                    state_d   = IDLE;
                    out_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                out_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_ack_q  <= 1'b0;
            out_req_q <= 1'b0;
            out_q     <= '0;
            div_q     <= 1'b0;
            bz_q      <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            in_ack_q  <= in_ack_d;
            out_req_q <= out_req_d;
            out_q     <= out_d;
            if (capture) begin
                div_q <= (in_op == `OP_DIV);
                bz_q  <= (in_b == '0);
                rd_q  <= in_rd;
            end
        end
    end

    assign in_ack   = in_ack_q;
    assign out_req  = out_req_q;
    assign out_data = out_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a queue of expected result bundles.
module tb_ex_stage;

    localparam logic [4:0] T_MOV = 5'h00, T_ADD = 5'h01, T_SUB = 5'h02, T_AND = 5'h03;
    localparam logic [4:0] T_OR  = 5'h04, T_NOT = 5'h05, T_CMP = 5'h06, T_MULT = 5'h07;
    localparam logic [4:0] T_DIV = 5'h08, T_OBC = 5'h09, T_VG  = 5'h0A, T_MLEFT = 5'h0B;
    localparam logic [4:0] T_MRIGHT = 5'h0C, T_STOP = 5'h0D, T_CONT = 5'h0E, T_BAD = 5'h1F;

    logic        clk = 1'b0;
    logic        reset;
    logic [41:0] in_data;
    logic        in_req;
    logic        in_ack;
    logic [28:0] out_data;
    logic        out_req;
    logic        out_ack;

    int passed = 0;
    int total  = 0;
    logic [28:0] sb[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .out_data (out_data),
        .out_req  (out_req),
        .out_ack  (out_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [28:0] bnd(input logic ill, input logic [1:0] cmd, input logic cv,
                                        input logic [3:0] fl, input logic wr,
                                        input logic [3:0] rd, input logic [15:0] res);
        return {ill, cmd, cv, fl, wr, rd, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd);
        in_data = {1'b1, b, a, op, rd};
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "/in_ack"}, 32'(in_ack), 32'd1);
    endtask

    // One full transaction; exp_lat = edges from capture until out_req is seen
    task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] rd,
                          input logic [28:0] exp, input int exp_lat);
        int n;
        logic [28:0] e;
        sb.push_back(exp);
        drive(op, a, b, rd);
        in_req = 1'b1;
        wait_ack(tag);
        in_req = 1'b0;
        n = 0;
        while (out_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (exp_lat >= 0) chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
        e = sb.pop_front();
        chk({tag, "/data"}, 32'(out_data), 32'(e));
        step();
        chk({tag, "/hold_req"}, 32'(out_req), 32'd1);
        chk({tag, "/ack_pulse"}, 32'(in_ack), 32'd0);
        chk({tag, "/hold_data"}, 32'(out_data), 32'(e));
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk({tag, "/req_drop"}, 32'(out_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [28:0] e;
        reset   = 1'b0;
        in_req  = 1'b0;
        out_ack = 1'b0;
        in_data = '0;
        step();
        step();
        chk("rst/in_ack", 32'(in_ack), 32'd0);
        chk("rst/out_req", 32'(out_req), 32'd0);
        chk("rst/out_data", 32'(out_data), 32'd0);
        reset = 1'b1;

        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("stray_ack/out_req", 32'(out_req), 32'd0);

        run_op("add_ovf", T_ADD, 16'h7FFF, 16'h0001, 4'd3, bnd(0, 2'b00, 0, 4'b0101, 1, 4'd3, 16'h8000), 0);
        run_op("cmp_eq", T_CMP, 16'd5, 16'd5, 4'd1, bnd(0, 2'b00, 0, 4'b1000, 0, 4'd1, 16'h0000), 0);
        run_op("sub_neg", T_SUB, 16'd3, 16'd5, 4'd2, bnd(0, 2'b00, 0, 4'b0110, 1, 4'd2, 16'hFFFE), 0);
        run_op("add_carry", T_ADD, 16'hFFFF, 16'h0001, 4'd2, bnd(0, 2'b00, 0, 4'b1010, 1, 4'd2, 16'h0000), 0);
        run_op("mult_big", T_MULT, 16'd300, 16'd300, 4'd4, bnd(0, 2'b00, 0, 4'b0011, 1, 4'd4, 16'h5F90), 17);
        run_op("mult_small", T_MULT, 16'd3, 16'd4, 4'd9, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd9, 16'h000C), 17);
        run_op("div", T_DIV, 16'd100, 16'd7, 4'd5, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd5, 16'h000E), 17);
        run_op("div_zero", T_DIV, 16'd9, 16'd0, 4'd6, bnd(0, 2'b00, 0, 4'b0101, 1, 4'd6, 16'hFFFF), 17);
        run_op("and", T_AND, 16'hF0F0, 16'h0FF0, 4'd1, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd1, 16'h00F0), 0);
        run_op("or_zero", T_OR, 16'h0000, 16'h0000, 4'd2, bnd(0, 2'b00, 0, 4'b1000, 1, 4'd2, 16'h0000), 0);
        run_op("not", T_NOT, 16'h00FF, 16'h1234, 4'd3, bnd(0, 2'b00, 0, 4'b0100, 1, 4'd3, 16'hFF00), 0);
        run_op("mov", T_MOV, 16'h1234, 16'hAAAA, 4'd4, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd4, 16'h1234), 0);
        run_op("obc_lt", T_OBC, 16'd3, 16'd9, 4'd5, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd5, 16'h0001), 0);
        run_op("obc_ge", T_OBC, 16'd9, 16'd3, 4'd5, bnd(0, 2'b00, 0, 4'b1000, 1, 4'd5, 16'h0000), 0);
        run_op("vg_clamp", T_VG, 16'd50, 16'd20, 4'd6, bnd(0, 2'b00, 0, 4'b0001, 1, 4'd6, 16'h0014), 0);
        run_op("vg_pass", T_VG, 16'd10, 16'd20, 4'd6, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd6, 16'h000A), 0);
        run_op("mv_right", T_MRIGHT, 16'h5555, 16'h3333, 4'd7, bnd(0, 2'b01, 1, 4'b0000, 0, 4'd7, 16'h0000), 0);
        run_op("mv_left", T_MLEFT, 16'h0001, 16'h0002, 4'd1, bnd(0, 2'b00, 1, 4'b0000, 0, 4'd1, 16'h0000), 0);
        run_op("stop", T_STOP, 16'h0000, 16'h0000, 4'hA, bnd(0, 2'b10, 1, 4'b0000, 0, 4'hA, 16'h0000), 0);
        run_op("continue", T_CONT, 16'hFFFF, 16'hFFFF, 4'hB, bnd(0, 2'b11, 1, 4'b0000, 0, 4'hB, 16'h0000), 0);
        run_op("illegal", T_BAD, 16'h1234, 16'h5678, 4'd0, bnd(1, 2'b00, 0, 4'b0000, 0, 4'd0, 16'h0000), 0);

        // Backpressure with the next request already waiting
        sb.push_back(bnd(0, 2'b00, 0, 4'b0000, 1, 4'd1, 16'h0005));
        drive(T_ADD, 16'd2, 16'd3, 4'd1);
        in_req = 1'b1;
        wait_ack("bp_first");
        drive(T_ADD, 16'd10, 16'd20, 4'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp/data_stable", 32'(out_data), 32'(sb[0]));
            chk("bp/in_ack_low", 32'(in_ack), 32'd0);
            chk("bp/out_req_high", 32'(out_req), 32'd1);
        end
        e = sb.pop_front();
        chk("bp/data_final", 32'(out_data), 32'(e));
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("bp/req_fall", 32'(out_req), 32'd0);
        chk("bp/no_early_capture", 32'(in_ack), 32'd0);
        sb.push_back(bnd(0, 2'b00, 0, 4'b0000, 1, 4'd2, 16'h001E));
        step();
        in_req = 1'b0;
        chk("bp/next_capture", 32'(in_ack), 32'd1);
        chk("bp/next_req", 32'(out_req), 32'd1);
        e = sb.pop_front();
        chk("bp/next_data", 32'(out_data), 32'(e));
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("bp/next_drop", 32'(out_req), 32'd0);

        // Reset in the middle of a multiply
        drive(T_MULT, 16'd300, 16'd300, 4'd4);
        in_req = 1'b1;
        wait_ack("rst_mult");
        in_req = 1'b0;
        repeat (8) step();
        chk("rst_mult/busy_req", 32'(out_req), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_mult/out_req", 32'(out_req), 32'd0);
        chk("rst_mult/in_ack", 32'(in_ack), 32'd0);
        chk("rst_mult/out_data", 32'(out_data), 32'd0);
        reset = 1'b1;
        repeat (20) step();
        chk("rst_mult/no_stale", 32'(out_req), 32'd0);
        run_op("post_rst_add", T_ADD, 16'd1, 16'd1, 4'd8, bnd(0, 2'b00, 0, 4'b0000, 1, 4'd8, 16'h0002), 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
